// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and assembles 32-bit little-endian words from a byte port.
// Define ICACHE_EN to add a direct-mapped word cache of 2^ICACHE_INDEX_W lines.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int unsigned ICACHE_INDEX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    output logic        mem_req,
    output logic [31:0] mem_a,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_pred,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] NUM_BYTES = CNT_W'(4);

    typedef enum logic [0:0] {
        ISSUE = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [1:0]          rcv_cnt_q, rcv_cnt_d;
    logic                inflight_q, inflight_d;
    logic [2:0][7:0]     lane_q, lane_d;
    logic [31:0]         pc_q, pc_d;
    logic                mem_req_q, mem_req_d;
    logic [31:0]         mem_a_q, mem_a_d;
    logic                if_valid_q, if_valid_d;
    logic [31:0]         if_inst_q, if_inst_d;
    logic [31:0]         if_pc_q, if_pc_d;
    logic                if_pred_q, if_pred_d;

    logic                granted_c;
    logic                last_byte_c;
    logic                hit_now_c;
    logic                hit_next_c;
    logic [31:0]         hit_inst_c;

    assign granted_c   = mem_req_q & mem_grant;
    assign last_byte_c = inflight_q && (rcv_cnt_q == 2'd3);

`ifdef ICACHE_EN
    localparam int unsigned LINES   = 1 << ICACHE_INDEX_W;
    localparam int unsigned TAG_LSB = ICACHE_INDEX_W + 2;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;

    logic [31:0]               line_data_q [LINES];
    logic [TAG_W-1:0]          line_tag_q  [LINES];
    logic [LINES-1:0]          line_valid_q;
    logic [ICACHE_INDEX_W-1:0] idx_now_c;
    logic [ICACHE_INDEX_W-1:0] idx_next_c;
    logic                      fill_en_c;

    assign idx_now_c  = pc_q[TAG_LSB-1:2];
    assign idx_next_c = pc_d[TAG_LSB-1:2];

    // A hit is only taken at the start of a fresh, aligned fetch.
    assign hit_now_c = (state_q == ISSUE) && (issue_cnt_q == '0) && (rcv_cnt_q == '0)
                       && !inflight_q && (pc_q[1:0] == 2'b00)
                       && line_valid_q[idx_now_c]
                       && (line_tag_q[idx_now_c] == pc_q[31:TAG_LSB]);
    assign hit_inst_c = line_data_q[idx_now_c];

    // Lookahead so the request is suppressed in the cycle the hit completes.
    assign hit_next_c = (state_d == ISSUE) && (issue_cnt_d == '0) && (rcv_cnt_d == '0)
                        && !inflight_d && (pc_d[1:0] == 2'b00)
                        && line_valid_q[idx_next_c]
                        && (line_tag_q[idx_next_c] == pc_d[31:TAG_LSB]);

    assign fill_en_c = rst && (state_q == ISSUE) && last_byte_c && !ex_redirect
                       && (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_valid_q <= '0;
        end else if (fill_en_c) begin
            line_valid_q[idx_now_c] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en_c) begin
            line_data_q[idx_now_c] <= {mem_din, lane_q};
            line_tag_q[idx_now_c]  <= pc_q[31:TAG_LSB];
        end
    end
`else
    assign hit_now_c  = 1'b0;
    assign hit_next_c = 1'b0;
    assign hit_inst_c = '0;
`endif

    // Fetch sequencing, byte capture, completion and redirect.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        inflight_d  = 1'b0;
        lane_d      = lane_q;
        pc_d        = pc_q;
        if_valid_d  = if_valid_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        if_pred_d   = if_pred_q;

        case (state_q)
            ISSUE: begin
                if (granted_c) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                inflight_d = granted_c;
                if (hit_now_c || last_byte_c) begin
                    if_inst_d   = hit_now_c ? hit_inst_c : {mem_din, lane_q};
                    if_pc_d     = pc_q;
                    if_pred_d   = pred_taken;
                    if_valid_d  = 1'b1;
                    pc_d        = pred_pc;
                    state_d     = HOLD;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                    inflight_d  = 1'b0;
                end else if (inflight_q) begin
                    case (rcv_cnt_q)
                        2'd0:    lane_d[0] = mem_din;
                        2'd1:    lane_d[1] = mem_din;
                        2'd2:    lane_d[2] = mem_din;
                        default: lane_d    = lane_q;
                    endcase
                    rcv_cnt_d = rcv_cnt_q + 2'd1;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    if_valid_d  = 1'b0;
                    state_d     = ISSUE;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                end
            end
            default: begin
                state_d = ISSUE;
            end
        endcase

        // Redirect overrides completion, stall and any byte still in flight.
        if (ex_redirect) begin
            pc_d        = ex_target;
            if_valid_d  = 1'b0;
            state_d     = ISSUE;
            issue_cnt_d = '0;
            rcv_cnt_d   = '0;
            inflight_d  = 1'b0;
        end
    end

    // Memory request for the upcoming cycle, derived from next state.
    always_comb begin
        mem_req_d = (state_d == ISSUE) && (issue_cnt_d < NUM_BYTES) && !hit_next_c;
        mem_a_d   = mem_req_d ? (pc_d + 32'(issue_cnt_d)) : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ISSUE;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            lane_q      <= '0;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_a_q     <= 32'h0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= 32'h0;
            if_pc_q     <= 32'h0;
            if_pred_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            inflight_q  <= inflight_d;
            lane_q      <= lane_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_a_q     <= mem_a_d;
            if_valid_q  <= if_valid_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            if_pred_q   <= if_pred_d;
        end
    end

    assign pc       = pc_q;
    assign mem_req  = mem_req_q;
    assign mem_a    = mem_a_q;
    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign if_pc    = if_pc_q;
    assign if_pred  = if_pred_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef ICACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        mem_grant;
    logic [7:0]  mem_din;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_pred;
    logic        ex_redirect;
    logic [31:0] ex_target;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .ICACHE_INDEX_W(8)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .mem_req(mem_req), .mem_a(mem_a), .mem_grant(mem_grant), .mem_din(mem_din),
        .id_ready(id_ready), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_pred(if_pred), .ex_redirect(ex_redirect), .ex_target(ex_target)
    );

    int errors = 0;
    int checks = 0;

    // Memory contents: a fixed boot word at 0..3, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0]  boot [4];
        logic [31:0] h;
        boot = '{8'h13, 8'h05, 8'h10, 8'h00};
        if (a < 32'd4) return boot[a[1:0]];
        h = a * 32'h9E3779B1;
        return h[31:24] ^ h[15:8];
    endfunction

    // Predictor used in random mode: {taken, next pc}.
    function automatic logic [32:0] pfn(input logic [31:0] p);
        logic [31:0] h;
        h = (p ^ 32'h5A5A1234) * 32'h85EBCA6B;
        if (h[28]) return {1'b1, 22'h0, h[13:6], 2'b00};
        return {1'b0, p + 32'd4};
    endfunction

    bit          dir_mode;
    logic [31:0] dir_pred_pc;
    logic        dir_pred_taken;
    logic [32:0] pv;
    assign pv         = dir_mode ? {dir_pred_taken, dir_pred_pc} : pfn(pc);
    assign pred_taken = pv[32];
    assign pred_pc    = pv[31:0];

    // Reference model: current fetch described as issued count, received byte queue, pending flag.
    logic [31:0] m_pc;
    bit          m_started, m_hold, m_valid, m_pend;
    logic [31:0] m_pend_a;
    int          m_nis;
    logic [7:0]  m_bytes [$];
    logic [31:0] m_out_inst, m_out_pc;
    logic        m_out_pred;
    bit          c_valid [256];
    logic [31:0] c_addr  [256];
    logic [31:0] c_data  [256];

    task automatic m_reset();
        m_pc = RESET_PC; m_started = 0; m_hold = 0; m_valid = 0; m_pend = 0;
        m_pend_a = 0; m_nis = 0; m_bytes.delete();
        m_out_inst = 0; m_out_pc = 0; m_out_pred = 0;
        for (int i = 0; i < 256; i++) c_valid[i] = 0;
    endtask

    function automatic bit m_hit();
        if (!CACHE || !m_started || m_hold) return 0;
        if (m_nis != 0 || m_bytes.size() != 0 || m_pend) return 0;
        if (m_pc[1:0] != 2'b00) return 0;
        return c_valid[m_pc[9:2]] && (c_addr[m_pc[9:2]] == m_pc);
    endfunction

    function automatic bit m_req();
        return m_started && !m_hold && (m_nis < 4) && !m_hit();
    endfunction

    task automatic m_complete(input logic [31:0] inst);
        logic [32:0] mp;
        mp = dir_mode ? {dir_pred_taken, dir_pred_pc} : pfn(m_pc);
        m_out_inst = inst; m_out_pc = m_pc; m_out_pred = mp[32];
        m_valid = 1; m_hold = 1; m_pc = mp[31:0];
        m_nis = 0; m_bytes.delete(); m_pend = 0;
    endtask

    task automatic model_step();
        bit          granted;
        logic [31:0] w;
        if (!rst) begin
            m_reset();
            return;
        end
        granted = m_req() && mem_grant;
        if (ex_redirect) begin
            m_pc = ex_target; m_valid = 0; m_hold = 0;
            m_nis = 0; m_bytes.delete(); m_pend = 0;
        end else if (m_hold) begin
            if (id_ready) begin
                m_valid = 0; m_hold = 0;
            end
        end else if (m_hit()) begin
            m_complete(c_data[m_pc[9:2]]);
        end else begin
            if (m_pend) m_bytes.push_back(mem_byte(m_pend_a));
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                if (CACHE && m_pc[1:0] == 2'b00) begin
                    c_valid[m_pc[9:2]] = 1; c_addr[m_pc[9:2]] = m_pc; c_data[m_pc[9:2]] = w;
                end
                m_complete(w);
            end else begin
                m_pend   = granted;
                m_pend_a = m_pc + 32'(m_nis);
                if (granted) m_nis++;
            end
        end
        m_started = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        bit er;
        er = m_req();
        chk("pc", pc, m_pc);
        chk("mem_req", 32'(mem_req), 32'(er));
        if (er) chk("mem_a", mem_a, m_pc + 32'(m_nis));
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
            chk("if_inst", if_inst, m_out_inst);
            chk("if_pc", if_pc, m_out_pc);
            chk("if_pred", 32'(if_pred), 32'(m_out_pred));
        end
    endtask

    // One clock: memory responder, model update, then compare away from the edge.
    task automatic tick();
        bit          rv;
        logic [31:0] ra;
        rv = mem_req && mem_grant;
        ra = mem_a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        mem_din = rv ? mem_byte(ra) : 8'($urandom);
        check_all();
    endtask

    task automatic count_to_valid(output int n);
        n = 0;
        while (!if_valid && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) chk("valid_timeout", 32'(n), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_a"}, mem_a, 32'h0);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_inst"}, if_inst, 32'h0);
        chk({tag, "_if_pc"}, if_pc, 32'h0);
        chk({tag, "_if_pred"}, 32'(if_pred), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 0; mem_grant = 0; id_ready = 0; ex_redirect = 0; ex_target = 0; mem_din = 0;
        dir_mode = 1; dir_pred_pc = 32'h4; dir_pred_taken = 0;
        m_reset();
        @(negedge clk);
        tick(); tick();
        chk_reset_outputs("reset");

        // Boot fetch at 0 with continuous grant.
        rst = 1; mem_grant = 1; id_ready = 1;
        tick();
        chk("boot_req", 32'(mem_req), 32'd1);
        chk("boot_a", mem_a, 32'h0);
        count_to_valid(n);
        chk("boot_latency", 32'(n), 32'd5);
        chk("boot_inst", if_inst, 32'h00100513);
        chk("boot_model_inst", m_out_inst, 32'h00100513);
        chk("boot_if_pc", if_pc, 32'h0);
        chk("boot_if_pred", 32'(if_pred), 32'd0);
        chk("boot_next_pc", pc, 32'h4);

        // Redirect during handshake, then refetch 0 with a toggling grant.
        ex_redirect = 1; ex_target = 32'h0;
        tick();
        ex_redirect = 0;
        chk("redir_hs_valid", 32'(if_valid), 32'd0);
        n = 0;
        while (!if_valid && n < 30) begin
            mem_grant = (n < 6) ? pat[n] : 1'b1;
            tick();
            n++;
        end
        chk("toggle_latency", 32'(n), CACHE ? 32'd1 : 32'd7);
        chk("toggle_inst", if_inst, 32'h00100513);

        // Stall after completion, predicted-taken next pc.
        mem_grant = 1; id_ready = 0; dir_pred_pc = 32'h100; dir_pred_taken = 1;
        ex_redirect = 1; ex_target = 32'h0;
        tick();
        ex_redirect = 0;
        count_to_valid(n);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_inst", if_inst, 32'h00100513);
            chk("stall_if_pc", if_pc, 32'h0);
            chk("stall_pred", 32'(if_pred), 32'd1);
            chk("stall_req", 32'(mem_req), 32'd0);
        end
        id_ready = 1;
        tick();
        chk("resume_a", mem_a, 32'h100);
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_valid", 32'(if_valid), 32'd0);

        // Redirect in the cycle after the second grant.
        tick(); tick();
        ex_redirect = 1; ex_target = 32'h200;
        tick();
        ex_redirect = 0;
        chk("redir_a", mem_a, 32'h200);
        chk("redir_pc", pc, 32'h200);
        mem_grant = 0;
        tick(); tick();
        chk("redir_no_valid", 32'(if_valid), 32'd0);

        // Redirect coincident with completion of a fetch at 0x40.
        ex_redirect = 1; ex_target = 32'h40;
        tick();
        ex_redirect = 0; mem_grant = 1;
        repeat (4) tick();
        chk("pre_complete_valid", 32'(if_valid), 32'd0);
        ex_redirect = 1; ex_target = 32'h200;
        tick();
        ex_redirect = 0;
        chk("drop_valid", 32'(if_valid), 32'd0);
        chk("drop_pc", pc, 32'h200);

        // Address wrap, then reset mid-fetch.
        ex_redirect = 1; ex_target = 32'hFFFFFFFE;
        tick();
        ex_redirect = 0;
        tick(); tick();
        chk("wrap_a", mem_a, 32'h0);
        rst = 0;
        tick();
        chk_reset_outputs("midreset");
        rst = 1;

`ifdef ICACHE_EN
        dir_pred_pc = 32'h4; dir_pred_taken = 0;
        tick();
        count_to_valid(n);
        ex_redirect = 1; ex_target = 32'h0;
        tick();
        ex_redirect = 0;
        chk("hit_req", 32'(mem_req), 32'd0);
        tick();
        chk("hit_valid", 32'(if_valid), 32'd1);
        chk("hit_req2", 32'(mem_req), 32'd0);
        chk("hit_inst", if_inst, 32'h00100513);
`endif

        // Randomized traffic.
        dir_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst         = ($urandom_range(0, 199) != 0);
            mem_grant   = ($urandom_range(0, 9) < 7);
            id_ready    = ($urandom_range(0, 9) < 6);
            ex_redirect = ($urandom_range(0, 29) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      ex_target = 32'hFFFFFFFE;
            else if (r == 1) ex_target = 32'($urandom_range(0, 1023));
            else             ex_target = {22'h0, 8'($urandom), 2'b00};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
